// File: rtl/swd_xfer_sequencer.sv
// swd_xfer_sequencer: sequences one SWD transaction (request, ACK, data, parity) with WAIT retries
// Ports:
//   sck, rst_n               clock (posedge) and asynchronous active-low reset
//   req_valid/req_ready      request handshake; req_apndp, req_rnw, req_addr (A[3:2]), req_wdata
//   rsp_valid/rsp_ready      response handshake; rsp_ack (first-sampled bit in [0]), rsp_rdata,
//                            rsp_perr, rsp_retries
//   fe_arm_n                 frontend reset: 0 = disarmed between frames, 1 = frame in progress
//   fe_rnw, fe_mosi, fe_miso frontend direction, outgoing and incoming line bits
//   busy                     high whenever a transaction is in progress
module swd_xfer_sequencer #(
  parameter int RETRY_MAX  = 15,
  parameter int GAP_CYCLES = 2
) (
  input  logic        sck,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_apndp,
  input  logic        req_rnw,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_ack,
  output logic [31:0] rsp_rdata,
  output logic        rsp_perr,
  output logic [3:0]  rsp_retries,
  output logic        fe_arm_n,
  output logic        fe_rnw,
  output logic        fe_mosi,
  input  logic        fe_miso,
  output logic        busy
);
  localparam logic [3:0] RMAX  = 4'(RETRY_MAX);
  localparam logic [3:0] GLAST = 4'(GAP_CYCLES - 1);
  typedef enum logic [3:0] {
    IDLE, ARM, REQ, TURN1, ACK, RDATA, RPAR, TAIL, TURN2, WDATA, WPAR, ABORT, GAP, RESP
  } state_t;
  state_t      state, state_nx;
  logic        apndp, rnw;
  logic [1:0]  addr;
  logic [31:0] wdata, rd_sh;
  logic [5:0]  k;
  logic [3:0]  gcnt;
  logic [7:0]  req_byte;
  logic        ack_ok, retry, frame;
  assign req_byte = {1'b1, 1'b0, apndp ^ rnw ^ addr[0] ^ addr[1], addr[1], addr[0], rnw, apndp, 1'b1};
  // the third ACK bit is still on the line when the branch is decided
  assign ack_ok   = {fe_miso, rsp_ack[1:0]} == 3'b001;
  assign retry    = rsp_ack == 3'b010 && rsp_retries < RMAX;
  assign frame    = state inside {REQ, TURN1, ACK, RDATA, RPAR, TAIL, TURN2, WDATA, WPAR, ABORT};
  always_ff @(posedge sck or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = ARM;
      ARM:     state_nx = REQ;
      REQ:     if (k == 6'd9) state_nx = TURN1;
      TURN1:   state_nx = ACK;
      ACK:     if (k == 6'd13) state_nx = ack_ok ? (rnw ? RDATA : TURN2) : ABORT;
      RDATA:   if (k == 6'd45) state_nx = RPAR;
      RPAR:    state_nx = TAIL;
      TAIL:    state_nx = GAP;
      TURN2:   state_nx = WDATA;
      WDATA:   if (k == 6'd46) state_nx = WPAR;
      WPAR:    state_nx = GAP;
      ABORT:   state_nx = GAP;
      GAP:     if (gcnt == GLAST) state_nx = retry ? ARM : RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE;
    busy      = state != IDLE;
    rsp_valid = state == RESP;
    fe_arm_n  = frame;
    fe_rnw    = (frame || state == ARM) ? rnw : 1'b1;
    fe_mosi   = (state == REQ && k >= 6'd2) ? req_byte[3'(k - 6'd2)] :
                state == WDATA ? wdata[5'(k - 6'd15)] :
                state == WPAR  ? ^wdata : 1'b0;
  end
  always_ff @(posedge sck or negedge rst_n)
    if (!rst_n) begin
      k           <= '0;
      gcnt        <= '0;
      apndp       <= 1'b0;
      rnw         <= 1'b1;
      addr        <= '0;
      wdata       <= '0;
      rd_sh       <= '0;
      rsp_ack     <= '0;
      rsp_rdata   <= '0;
      rsp_perr    <= 1'b0;
      rsp_retries <= '0;
    end else begin
      k    <= state == ARM ? 6'd0 : k + 6'd1;
      gcnt <= state == GAP ? gcnt + 4'd1 : 4'd0;
      if (state == IDLE && req_valid) begin
        apndp       <= req_apndp;
        rnw         <= req_rnw;
        addr        <= req_addr;
        wdata       <= req_wdata;
        rsp_retries <= '0;
        rsp_perr    <= 1'b0;
      end
      if (state == ACK) rsp_ack[2'(k - 6'd11)] <= fe_miso;
      if (state == RDATA) rd_sh <= {fe_miso, rd_sh[31:1]};
      // only a completed OK read touches the visible read data
      if (state == RPAR) begin
        rsp_rdata <= rd_sh;
        rsp_perr  <= fe_miso ^ (^rd_sh);
      end
      if (state == GAP && gcnt == GLAST && retry) rsp_retries <= rsp_retries + 4'd1;
    end
endmodule

// File: tb/tb_swd_xfer_sequencer.sv
// tb_swd_xfer_sequencer: directed bench with a cycle-timeline model of SWD frames
module tb_swd_xfer_sequencer;
  logic sck = 0, rst_n = 0, req_valid = 0, rsp_ready = 0, sel = 0;
  logic apndp = 0, rnw = 0, fe_miso = 1;
  logic [1:0] addr = 0;
  logic [31:0] wdata = 0;
  logic rr0, v0, perr0, arm0, frnw0, mosi0, busy0;
  logic rr1, v1, perr1, arm1, frnw1, mosi1, busy1;
  logic [2:0] ack0, ack1;
  logic [31:0] rd0, rd1;
  logic [3:0] ret0, ret1;
  logic [5:0] obs;
  logic [2:0] o_ack;
  logic [31:0] o_rd;
  logic [3:0] o_ret;
  logic o_perr;
  logic [31:0] last_rd [2];
  int vecs = 0, errs = 0;
  logic [7:0] ob;
  logic [31:0] ow;
  logic op;
  int vi;

  always #5 sck = ~sck;

  swd_xfer_sequencer dut0 (
    .sck(sck), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(rr0),
    .req_apndp(apndp), .req_rnw(rnw), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(v0), .rsp_ready(rsp_ready & ~sel), .rsp_ack(ack0), .rsp_rdata(rd0),
    .rsp_perr(perr0), .rsp_retries(ret0), .fe_arm_n(arm0), .fe_rnw(frnw0),
    .fe_mosi(mosi0), .fe_miso(fe_miso), .busy(busy0));

  swd_xfer_sequencer #(.RETRY_MAX(1)) dut1 (
    .sck(sck), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rr1),
    .req_apndp(apndp), .req_rnw(rnw), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(v1), .rsp_ready(rsp_ready & sel), .rsp_ack(ack1), .rsp_rdata(rd1),
    .rsp_perr(perr1), .rsp_retries(ret1), .fe_arm_n(arm1), .fe_rnw(frnw1),
    .fe_mosi(mosi1), .fe_miso(fe_miso), .busy(busy1));

  // {req_ready, fe_arm_n, fe_mosi, fe_rnw, busy, rsp_valid}
  assign obs    = sel ? {rr1, arm1, mosi1, frnw1, busy1, v1} : {rr0, arm0, mosi0, frnw0, busy0, v0};
  assign o_ack  = sel ? ack1 : ack0;
  assign o_rd   = sel ? rd1 : rd0;
  assign o_ret  = sel ? ret1 : ret0;
  assign o_perr = sel ? perr1 : perr0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rsp(input string nm, input logic [2:0] a, input logic [3:0] r,
                         input logic [31:0] d, input logic p);
    chk({nm, " ack"}, o_ack, a);
    chk({nm, " retries"}, o_ret, r);
    chk({nm, " rdata"}, o_rd, d);
    chk({nm, " perr"}, o_perr, p);
  endtask

  // The model lays out every cycle after acceptance: ARM, the frame bits, the gap, RESP, IDLE.
  task automatic xfer(input string nm, input logic s, input logic ap, input logic rw,
                      input logic [1:0] ad, input logic [31:0] wd, input logic [3:0][2:0] acks,
                      input logic [31:0] rd, input logic rp, input int rwait, input int rst_at,
                      output logic [7:0] o_byte, output logic [31:0] o_wd, output logic o_wpar,
                      output int o_vidx);
    logic [5:0] eq[$];
    logic mq[$], rq[$], mo[$];
    int rmax, r;
    logic [2:0] a;
    logic [7:0] rb;
    logic ok, e_perr;
    rmax = s ? 1 : 15;
    r = 0;
    o_vidx = -1;
    rb = {1'b1, 1'b0, ap ^ rw ^ ad[0] ^ ad[1], ad[1], ad[0], rw, ap, 1'b1};
    forever begin
      a = acks[r > 3 ? 3 : r];
      ok = a == 3'b001;
      eq.push_back({3'b000, rw, 2'b10}); mq.push_back(1); rq.push_back(0);
      for (int b = 0; b < (ok ? 48 : 15); b++) begin
        logic m, t;
        m = (b >= 2 && b <= 9) ? rb[b-2] :
            (!rw && ok && b >= 15 && b <= 46) ? wd[b-15] :
            (!rw && ok && b == 47) ? ^wd : 1'b0;
        t = (b >= 11 && b <= 13) ? a[b-11] :
            (rw && ok && b >= 14 && b <= 45) ? rd[b-14] :
            (rw && ok && b == 46) ? rp : 1'b1;
        eq.push_back({2'b01, m, rw, 2'b10}); mq.push_back(t); rq.push_back(0);
      end
      for (int g = 0; g < 2; g++) begin
        eq.push_back(6'b000110); mq.push_back(1); rq.push_back(0);
      end
      if (a == 3'b010 && r < rmax) r++;
      else break;
    end
    for (int w = 0; w <= rwait; w++) begin
      eq.push_back(6'b000111); mq.push_back(1); rq.push_back(w == rwait);
    end
    eq.push_back(6'b100100); mq.push_back(1); rq.push_back(0);
    e_perr = 0;
    if (rw && ok) begin
      e_perr = rp != ^rd;
      last_rd[s] = rd;
    end
    @(negedge sck);
    sel = s; apndp = ap; rnw = rw; addr = ad; wdata = wd; req_valid = 1;
    @(posedge sck);
    for (int i = 0; i < eq.size(); i++) begin
      @(negedge sck);
      req_valid = 0; fe_miso = mq[i]; rsp_ready = rq[i];
      chk($sformatf("%s cyc%0d", nm, i), obs, eq[i]);
      mo.push_back(obs[3]);
      if (eq[i][0] && (o_vidx < 0 || rq[i])) chk_rsp(nm, a, 4'(r), last_rd[s], e_perr);
      if (eq[i][0] && o_vidx < 0) o_vidx = i + 1;
      if (i == rst_at) begin
        #2 rst_n = 0;
        #1 chk({nm, " async reset"}, {obs[4], obs[1], obs[0]}, 3'b000);
        @(posedge sck);
        #1 rst_n = 1;
        last_rd[0] = 0; last_rd[1] = 0; rsp_ready = 0; fe_miso = 1;
        break;
      end
    end
    o_byte = 0; o_wd = 0; o_wpar = 0;
    if (mo.size() > 48) begin
      for (int b = 0; b < 8; b++) o_byte[b] = mo[3+b];
      for (int b = 0; b < 32; b++) o_wd[b] = mo[16+b];
      o_wpar = mo[48];
    end else if (mo.size() > 10)
      for (int b = 0; b < 8; b++) o_byte[b] = mo[3+b];
  endtask

  initial begin
    last_rd[0] = 0; last_rd[1] = 0;
    #3 chk("reset outputs", obs, 6'b100100);
    chk_rsp("reset", 3'b000, 4'd0, 32'd0, 1'b0);
    #9 rst_n = 1;
    @(negedge sck);
    chk("idle after reset", obs, 6'b100100);

    xfer("dp read", 0, 0, 1, 2'd0, 0, {4{3'b001}}, 32'h12345678, 1, 0, -1, ob, ow, op, vi);
    chk("dp read request byte", ob, 8'hA5);
    chk("dp read valid time", vi, 52);
    chk("dp read rdata pin", o_rd, 32'h12345678);

    xfer("dp read badpar", 0, 0, 1, 2'd0, 0, {4{3'b001}}, 32'h12345678, 0, 2, -1, ob, ow, op, vi);
    chk("badpar perr pin", o_perr, 1'b1);

    xfer("ap write", 0, 1, 0, 2'd3, 32'hDEADBEEF, {4{3'b001}}, 0, 0, 0, -1, ob, ow, op, vi);
    chk("ap write request byte", ob, 8'hBB);
    chk("ap write data bits", ow, 32'hDEADBEEF);
    chk("ap write parity bit", op, 1'b0);

    xfer("wait wait ok", 0, 0, 1, 2'd1, 0, {3'b001, 3'b001, 3'b010, 3'b010}, 32'hCAFE0001, 0, 1, -1, ob, ow, op, vi);
    chk("retry count pin", o_ret, 4'd2);

    xfer("no target", 0, 1, 1, 2'd2, 0, {4{3'b111}}, 0, 0, 0, -1, ob, ow, op, vi);
    chk("no target valid time", vi, 19);
    chk("no target rdata kept", o_rd, 32'hCAFE0001);

    xfer("fault write", 0, 0, 0, 2'd2, 32'h0F0F0F0F, {4{3'b100}}, 0, 0, 0, -1, ob, ow, op, vi);

    xfer("wait saturate", 0, 1, 1, 2'd0, 0, {4{3'b010}}, 0, 0, 0, -1, ob, ow, op, vi);
    chk("saturated retries", o_ret, 4'd15);

    xfer("retry max 1", 1, 0, 1, 2'd0, 0, {4{3'b010}}, 0, 0, 0, -1, ob, ow, op, vi);
    chk("retry max 1 valid time", vi, 37);
    chk("retry max 1 ack", o_ack, 3'b010);

    sel = 0;
    xfer("reset mid read", 0, 0, 1, 2'd0, 0, {4{3'b001}}, 32'h55AA33CC, 1, 0, 21, ob, ow, op, vi);
    chk("no response after reset", vi, -1);
    for (int i = 0; i < 4; i++) begin
      @(negedge sck);
      chk("idle after mid reset", obs, 6'b100100);
    end
    chk_rsp("after mid reset", 3'b000, 4'd0, 32'd0, 1'b0);
    xfer("read after reset", 0, 0, 1, 2'd0, 0, {4{3'b001}}, 32'h80000001, 1, 0, -1, ob, ow, op, vi);
    chk("read after reset valid time", vi, 52);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
